// File: rtl/sram_ctrl_p_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_p_if
// Description : Request/response bundle between a CPU-side master and the
//               sram_ctrl_p controller.
//               Request  : req_valid/req_ready handshake, req_wr_n (0 = write),
//                          req_addr, req_wdata, req_be.
//               Response : rsp_valid/rsp_ready handshake, rsp_rdata,
//                          rsp_is_wr, rsp_err, plus the busy status flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_p_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr_n;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_is_wr;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_wr_n, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_wr_n, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_wr, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_p
// Description : Single-port SRAM controller with MAR/MDR request capture,
//               byte-lane writes, programmable wait states and a registered
//               valid/ready response.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - sram_ctrl_p_if slave modport (request, response, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl_p #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int DEPTH       = 2048,
    parameter int WAIT_STATES = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    sram_ctrl_p_if.slave  bus
);
    localparam int              c_be_w      = DATA_W / 8;
    localparam int              c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_in_range;
    logic                w_mem_we;
    logic [c_idx_w-1:0]  w_idx;

    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic [c_be_w-1:0]   r_be;
    logic                r_wr_n;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_is_wr;
    logic                r_err;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Full-width compare: out-of-range addresses never alias onto the array.
    assign w_in_range = {1'b0, r_mar} < c_depth;
    assign w_idx      = r_mar[c_idx_w-1:0];
    // Gating with reset makes a reset asserted during ACCESS suppress the write.
    assign w_mem_we   = (r_state == S_ACCESS) && !r_wr_n && w_in_range && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_be    <= '0;
            r_wr_n  <= 1'b0;
            r_rdata <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mar  <= bus.req_addr;
                r_mdr  <= bus.req_wdata;
                r_be   <= bus.req_be;
                r_wr_n <= bus.req_wr_n;
                r_cnt  <= c_wait_load;
            end
            if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_ACCESS) begin
                r_is_wr <= ~r_wr_n;
                r_err   <= ~w_in_range;
                r_rdata <= (r_wr_n && w_in_range) ? r_mem[w_idx] : '0;
            end
            // Read data deliberately survives the return to IDLE.
            if (r_state == S_RESP && bus.rsp_ready) begin
                r_is_wr <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; only lanes with a set byte enable are touched.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_be_w; i++) begin
                if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_mdr[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_is_wr = r_is_wr;
    assign bus.rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl_p
// Description : Self-checking bench for sram_ctrl_p. Three instances:
//               0: WAIT_STATES=0, DEPTH=2048
//               1: WAIT_STATES=3, DEPTH=1024
//               2: WAIT_STATES=2, DEPTH=2048
//               Expected responses are queued at issue time and popped by an
//               independent monitor when a response is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  tv_valid, tv_wr_n, tv_rready;
    logic [10:0] tv_addr  [3];
    logic [15:0] tv_wdata [3];
    logic [1:0]  tv_be    [3];

    wire  [2:0]  ov_ready, ov_valid, ov_iswr, ov_err, ov_busy;
    wire  [15:0] ov_rdata [3];

    sram_ctrl_p_if #(.DATA_W(16), .ADDR_W(11)) b0 ();
    sram_ctrl_p_if #(.DATA_W(16), .ADDR_W(11)) b1 ();
    sram_ctrl_p_if #(.DATA_W(16), .ADDR_W(11)) b2 ();

    assign b0.req_valid = tv_valid[0];  assign b1.req_valid = tv_valid[1];  assign b2.req_valid = tv_valid[2];
    assign b0.req_wr_n  = tv_wr_n[0];   assign b1.req_wr_n  = tv_wr_n[1];   assign b2.req_wr_n  = tv_wr_n[2];
    assign b0.req_addr  = tv_addr[0];   assign b1.req_addr  = tv_addr[1];   assign b2.req_addr  = tv_addr[2];
    assign b0.req_wdata = tv_wdata[0];  assign b1.req_wdata = tv_wdata[1];  assign b2.req_wdata = tv_wdata[2];
    assign b0.req_be    = tv_be[0];     assign b1.req_be    = tv_be[1];     assign b2.req_be    = tv_be[2];
    assign b0.rsp_ready = tv_rready[0]; assign b1.rsp_ready = tv_rready[1]; assign b2.rsp_ready = tv_rready[2];

    assign ov_ready[0] = b0.req_ready;  assign ov_ready[1] = b1.req_ready;  assign ov_ready[2] = b2.req_ready;
    assign ov_valid[0] = b0.rsp_valid;  assign ov_valid[1] = b1.rsp_valid;  assign ov_valid[2] = b2.rsp_valid;
    assign ov_iswr[0]  = b0.rsp_is_wr;  assign ov_iswr[1]  = b1.rsp_is_wr;  assign ov_iswr[2]  = b2.rsp_is_wr;
    assign ov_err[0]   = b0.rsp_err;    assign ov_err[1]   = b1.rsp_err;    assign ov_err[2]   = b2.rsp_err;
    assign ov_busy[0]  = b0.busy;       assign ov_busy[1]  = b1.busy;       assign ov_busy[2]  = b2.busy;
    assign ov_rdata[0] = b0.rsp_rdata;  assign ov_rdata[1] = b1.rsp_rdata;  assign ov_rdata[2] = b2.rsp_rdata;

    sram_ctrl_p #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .WAIT_STATES(0))
        u_dut0 (.clk(clk), .reset(rst_v[0]), .bus(b0));
    sram_ctrl_p #(.DATA_W(16), .ADDR_W(11), .DEPTH(1024), .WAIT_STATES(3))
        u_dut1 (.clk(clk), .reset(rst_v[1]), .bus(b1));
    sram_ctrl_p #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .WAIT_STATES(2))
        u_dut2 (.clk(clk), .reset(rst_v[2]), .bus(b2));

    typedef struct packed {
        logic [1:0]  k;
        logic        wr;
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is consumed on the edge after valid&&ready is seen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov_valid[k] && tv_rready[k]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_instance", 32'(k), 32'(e.k));
                    chk("rsp_is_wr", 32'(ov_iswr[k]), 32'(e.wr));
                    chk("rsp_err", 32'(ov_err[k]), 32'(e.err));
                    chk("rsp_rdata", 32'(ov_rdata[k]), 32'(e.rd));
                end
            end
        end
    end

    task automatic check_idle(input int k, input logic [15:0] rd);
        chk("idle_req_ready", 32'(ov_ready[k]), 32'd1);
        chk("idle_rsp_valid", 32'(ov_valid[k]), 32'd0);
        chk("idle_busy", 32'(ov_busy[k]), 32'd0);
        chk("idle_rsp_is_wr", 32'(ov_iswr[k]), 32'd0);
        chk("idle_rsp_err", 32'(ov_err[k]), 32'd0);
        chk("idle_rsp_rdata", 32'(ov_rdata[k]), 32'(rd));
    endtask

    task automatic wait_ready(input int k);
        int t = 0;
        @(negedge clk);
        while (!ov_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ov_ready[k]) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    // wr=1 issues a write. hold = cycles of rsp_ready=0 after rsp_valid rises.
    // spam keeps a conflicting write to 0x000 on the request port while busy.
    task automatic issue(input int k, input logic wr, input logic [10:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         input logic e_err, input logic [15:0] e_rd,
                         input int hold, input bit spam);
        int lat = 0;
        bit got = 0;
        exp_t e;
        wait_ready(k);
        if (hold > 0) tv_rready[k] = 1'b0;
        tv_valid[k] = 1'b1;
        tv_wr_n[k]  = ~wr;
        tv_addr[k]  = a;
        tv_wdata[k] = d;
        tv_be[k]    = be;
        e.k = 2'(k); e.wr = wr; e.err = e_err; e.rd = e_rd;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (spam) begin
            tv_wr_n[k]  = 1'b0;
            tv_addr[k]  = 11'h000;
            tv_wdata[k] = 16'hDEAD;
            tv_be[k]    = 2'b11;
        end else begin
            tv_valid[k] = 1'b0;
            tv_wr_n[k]  = wr;
            tv_addr[k]  = ~a;
            tv_wdata[k] = ~d;
            tv_be[k]    = ~be;
        end
        chk("busy_after_accept", 32'(ov_busy[k]), 32'd1);
        chk("ready_after_accept", 32'(ov_ready[k]), 32'd0);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ov_valid[k]) got = 1;
            else begin
                chk("ready_low_while_busy", 32'(ov_ready[k]), 32'd0);
                chk("busy_high_while_busy", 32'(ov_busy[k]), 32'd1);
            end
        end
        chk("latency_edges", 32'(lat), 32'(wait_of(k) + 1));
        tv_valid[k] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", 32'(ov_valid[k]), 32'd1);
            chk("hold_rsp_rdata", 32'(ov_rdata[k]), 32'(e_rd));
            chk("hold_rsp_err", 32'(ov_err[k]), 32'(e_err));
            chk("hold_rsp_is_wr", 32'(ov_iswr[k]), 32'(wr));
            @(posedge clk); #1;
        end
        tv_rready[k] = 1'b1;
        @(posedge clk); #1;
        check_idle(k, e_rd);
    endtask

    // Start a write and assert reset 'edges' clock edges after the accept.
    task automatic reset_mid(input int k, input logic [10:0] a, input logic [15:0] d, input int edges);
        wait_ready(k);
        tv_valid[k] = 1'b1;
        tv_wr_n[k]  = 1'b0;
        tv_addr[k]  = a;
        tv_wdata[k] = d;
        tv_be[k]    = 2'b11;
        @(posedge clk); #1;
        tv_valid[k] = 1'b0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_before_reset", 32'(ov_busy[k]), 32'd1);
        #2 rst_v[k] = 1'b1;
        #1 check_idle(k, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_v[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v     = 3'b111;
        tv_valid  = 3'b000;
        tv_wr_n   = 3'b111;
        tv_rready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tv_addr[k]  = '0;
            tv_wdata[k] = '0;
            tv_be[k]    = '0;
        end
        #1;
        for (int k = 0; k < 3; k++) check_idle(k, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_v = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) check_idle(k, 16'h0000);

        // Defaults, W=0: write then read back.
        issue(0, 1'b1, 11'h005, 16'hBEEF, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
        issue(0, 1'b0, 11'h005, 16'h0000, 2'b11, 1'b0, 16'hBEEF, 0, 1'b0);

        // Byte enables.
        issue(0, 1'b1, 11'h010, 16'h1234, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
        issue(0, 1'b1, 11'h010, 16'hABCD, 2'b01, 1'b0, 16'h0000, 0, 1'b0);
        issue(0, 1'b0, 11'h010, 16'h0000, 2'b00, 1'b0, 16'h12CD, 0, 1'b0);
        issue(0, 1'b1, 11'h010, 16'hABCD, 2'b10, 1'b0, 16'h0000, 0, 1'b0);
        issue(0, 1'b0, 11'h010, 16'h0000, 2'b00, 1'b0, 16'hABCD, 0, 1'b0);
        issue(0, 1'b1, 11'h010, 16'h0000, 2'b00, 1'b0, 16'h0000, 0, 1'b0);
        issue(0, 1'b0, 11'h010, 16'h0000, 2'b00, 1'b0, 16'hABCD, 0, 1'b0);

        // W=3, DEPTH=1024: seed 0x000, ignored requests while busy, backpressure.
        issue(1, 1'b1, 11'h000, 16'h1111, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
        issue(1, 1'b1, 11'h123, 16'h5A5A, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
        issue(1, 1'b0, 11'h123, 16'h0000, 2'b00, 1'b0, 16'h5A5A, 0, 1'b1);
        issue(1, 1'b0, 11'h123, 16'h0000, 2'b00, 1'b0, 16'h5A5A, 5, 1'b0);
        issue(1, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0, 16'h1111, 0, 1'b0);

        // Out of range: error responses, no aliasing onto 0x000.
        issue(1, 1'b1, 11'h400, 16'h07FF, 2'b11, 1'b1, 16'h0000, 0, 1'b0);
        issue(1, 1'b0, 11'h400, 16'h0000, 2'b00, 1'b1, 16'h0000, 3, 1'b0);
        issue(1, 1'b0, 11'h7FF, 16'h0000, 2'b00, 1'b1, 16'h0000, 0, 1'b0);
        issue(1, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0, 16'h1111, 0, 1'b0);

        // W=2: reset during WAIT and during ACCESS drops the write.
        issue(2, 1'b1, 11'h020, 16'h5555, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
        issue(2, 1'b0, 11'h020, 16'h0000, 2'b00, 1'b0, 16'h5555, 0, 1'b0);
        reset_mid(2, 11'h020, 16'hAAAA, 0);
        issue(2, 1'b0, 11'h020, 16'h0000, 2'b00, 1'b0, 16'h5555, 0, 1'b0);
        reset_mid(2, 11'h020, 16'hCCCC, 2);
        issue(2, 1'b0, 11'h020, 16'h0000, 2'b00, 1'b0, 16'h5555, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_ctrl_p.md
Name: sram_ctrl_p

Overview:
- Parametrised successor to the 16-bit/11-bit SRAM wrapper.
- Registers address and data on request (MAR/MDR style) and holds an internal memory array with byte-lane writes.
- Inserts a programmable number of wait states, then returns a registered response over a valid/ready handshake.
- Sits between the CPU datapath and storage; replaces the bidirectional-bus interface with separate data-in and data-out paths.

Parameters:
- DATA_W, 16, data word width; must be a multiple of 8.
- ADDR_W, 11, address width.
- DEPTH, 2048, implemented words; DEPTH <= 2**ADDR_W.
- WAIT_STATES, 0, extra cycles between request accept and array access (0..15).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr_n  in  1  0 = write, 1 = read (codebase wr polarity).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for write responses.
- rsp_is_wr  out  1  response belongs to a write.
- rsp_err  out  1  address was >= DEPTH.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: async assert forces state IDLE and clears wait counter, MAR, MDR, BE and wr_n registers. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_is_wr=0, rsp_err=0, busy=0. Memory contents are not cleared.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - Accept on edge with req_valid=1: latch addr to MAR, wdata to MDR, be, wr_n.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - req_valid=0 stays in IDLE.
- WAIT:
  - Counter loads WAIT_STATES-1 at accept and decrements each edge.
  - At 0, go to ACCESS. Dwell is exactly WAIT_STATES cycles.
- ACCESS:
  - One cycle; next state is RESP.
  - Write with MAR<DEPTH: every byte lane with be=1 is written from MDR; other lanes are unchanged. rsp_rdata=0.
  - Read with MAR<DEPTH: mem[MAR] is registered to rsp_rdata.
  - MAR>=DEPTH: no write occurs, rsp_rdata=0, rsp_err=1.
  - be=0 write: completes normally with no change to memory.
- RESP:
  - rsp_valid=1.
  - rsp_rdata, rsp_is_wr and rsp_err are held stable while rsp_ready=0.
  - On edge with rsp_ready=1, go to IDLE. rsp_valid, rsp_err and rsp_is_wr clear; rsp_rdata holds its value.
- Latency: rsp_valid rises WAIT_STATES+1 edges after the accept edge.
- Throughput: one request per WAIT_STATES+3 cycles with rsp_ready tied high.
- req_ready=0 in WAIT, ACCESS and RESP. Requests presented there are ignored, not queued.
- Request inputs are sampled only on the accept edge; later changes have no effect.
- Read-after-write to the same address returns the new data.
- Reset mid-operation: the transaction is dropped. A write not yet in ACCESS never reaches memory. Reset asserted during ACCESS wins: no write occurs. No response is produced.
- Address compare uses the full ADDR_W bits; there is no wrap-around aliasing.

Test Plan:
1. Defaults, W=0: write addr 0x005 data 0xBEEF be=11, then read 0x005 -> write response rsp_is_wr=1, rsp_rdata=0; read response rsp_rdata=0xBEEF; each rsp_valid 1 edge after accept.
2. Byte enables: mem[0x010]=0x1234, write 0xABCD be=01, read -> 0x12CD; write 0xABCD be=10, read -> 0xABCD; write be=00 -> unchanged.
3. WAIT_STATES=3: read request -> rsp_valid rises exactly 4 edges after accept; req_ready=0 and busy=1 throughout; a second req_valid during WAIT is not accepted.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err held constant; rsp_ready=1 -> IDLE next edge, req_ready=1.
5. DEPTH=1024: write 0x7FF to addr 0x400, then read 0x400 -> both responses rsp_err=1, read rsp_rdata=0; mem[0x000] unchanged (no aliasing).
6. Reset: with W=2, assert reset during WAIT of a write to 0x020 (prior mem[0x020]=0x5555) -> outputs at reset values immediately (async); after release, read 0x020 returns 0x5555.
